// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle for the pipelined add/subtract unit.
// The master drives operations and consumes results; the slave is the adder.
interface addsub_pipe_if #(
  parameter int WIDTH = 8
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             op_sub;
  logic             op_carry;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_c;
  logic             flag_z;
  logic             flag_n;
  logic             flag_v;

  modport master (
    output flush, in_valid, a, b, op_sub, op_carry, carry_in, out_ready,
    input  in_ready, out_valid, result, flag_c, flag_z, flag_n, flag_v
  );

  modport slave (
    input  flush, in_valid, a, b, op_sub, op_carry, carry_in, out_ready,
    output in_ready, out_valid, result, flag_c, flag_z, flag_n, flag_v
  );
endinterface

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract with ALU flags: the carry chain is cut into CHUNK-bit
// slices, one register stage per slice, under valid/ready flow control.
module addsub_pipe #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input logic          clk,
  input logic          reset,
  addsub_pipe_if.slave bus
);
  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  logic             adv;
  logic [WIDTH-1:0] bx_in;
  logic             cin;

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] carry_q, carry_d;
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  bx_q  [STAGES];
  logic [WIDTH-1:0]  bx_d  [STAGES];
  logic              z_q, z_d;
  logic              v_q, v_d;

  logic [STAGES-1:0] st_valid;
  logic [STAGES-1:0] st_carry;
  logic [WIDTH-1:0]  st_a   [STAGES];
  logic [WIDTH-1:0]  st_bx  [STAGES];
  logic [WIDTH-1:0]  st_sum [STAGES];
  logic [CHUNK:0]    slice  [STAGES];
  logic [STAGES-1:0] load;

  always_comb begin
    bx_in = bus.op_sub ? ~bus.b : bus.b;
    cin   = bus.op_carry ? bus.carry_in : bus.op_sub;
    adv   = !valid_q[LAST] || bus.out_ready;
  end

  // Stage k is fed by the operation entering the unit (k = 0) or by stage k-1.
  always_comb begin
    st_valid[0] = bus.in_valid;
    st_carry[0] = cin;
    st_a[0]     = bus.a;
    st_bx[0]    = bx_in;
    st_sum[0]   = '0;
    for (int k = 1; k < STAGES; k++) begin
      st_valid[k] = valid_q[k-1];
      st_carry[k] = carry_q[k-1];
      st_a[k]     = a_q[k-1];
      st_bx[k]    = bx_q[k-1];
      st_sum[k]   = sum_q[k-1];
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (bus.flush) begin
      valid_d = '0;
    end else if (adv) begin
      valid_d = st_valid;
    end

    for (int k = 0; k < STAGES; k++) begin
      slice[k] = {1'b0, st_a[k][k*CHUNK +: CHUNK]}
               + {1'b0, st_bx[k][k*CHUNK +: CHUNK]}
               + {{CHUNK{1'b0}}, st_carry[k]};
      load[k]    = adv && !bus.flush && st_valid[k];
      sum_d[k]   = sum_q[k];
      carry_d[k] = carry_q[k];
      a_d[k]     = a_q[k];
      bx_d[k]    = bx_q[k];
      if (load[k]) begin
        sum_d[k]                   = st_sum[k];
        sum_d[k][k*CHUNK +: CHUNK] = slice[k][CHUNK-1:0];
        carry_d[k]                 = slice[k][CHUNK];
        a_d[k]                     = st_a[k];
        bx_d[k]                    = st_bx[k];
      end
    end

    // Data only moves with a real operation, so the output keeps its last result across bubbles and flushes.
    z_d = z_q;
    v_d = v_q;
    if (load[LAST]) begin
      z_d = (sum_d[LAST] == '0);
      v_d = (st_a[LAST][WIDTH-1] == st_bx[LAST][WIDTH-1]) &&
            (sum_d[LAST][WIDTH-1] != st_a[LAST][WIDTH-1]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      carry_q <= '0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        bx_q[k]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      z_q     <= z_d;
      v_q     <= v_d;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= sum_d[k];
        a_q[k]   <= a_d[k];
        bx_q[k]  <= bx_d[k];
      end
    end
  end

  assign bus.in_ready  = adv || bus.flush;
  assign bus.out_valid = valid_q[LAST];
  assign bus.result    = sum_q[LAST];
  assign bus.flag_c    = carry_q[LAST];
  assign bus.flag_n    = sum_q[LAST][WIDTH-1];
  assign bus.flag_z    = z_q;
  assign bus.flag_v    = v_q;
endmodule
